// File: rtl/ldst_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default data-memory depth.
package ldst_pkg;

    localparam int NUM_PALABRAS_DEF = 32;

    localparam logic [1:0] TAM_BYTE    = 2'b00;
    localparam logic [1:0] TAM_MEDIA   = 2'b01;
    localparam logic [1:0] TAM_PALABRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        LEER,
        ESCRIBIR,
        RESP
    } estado_t;

endpackage

// File: rtl/alineador_bytes.sv
// Little-endian lane steering: extracts and extends a load lane from a word,
// and merges a store lane into a word for read-modify-write.
module alineador_bytes
    import ldst_pkg::*;
(
    input  logic [31:0] palabra_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  tamano_i,
    input  logic        sin_signo_i,
    input  logic [31:0] dato_st_i,
    output logic [31:0] carga_o,
    output logic [31:0] fusion_o
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign sh_b   = {offset_i, 3'b000};
    assign sh_h   = {offset_i[1], 4'b0000};
    assign lane_b = palabra_i[sh_b +: 8];
    assign lane_h = offset_i[1] ? palabra_i[31:16] : palabra_i[15:0];

    always_comb begin
        carga_o  = palabra_i;
        fusion_o = dato_st_i;
        case (tamano_i)
            TAM_BYTE: begin
                carga_o  = {{24{~sin_signo_i & lane_b[7]}}, lane_b};
                fusion_o = (palabra_i & ~(32'h0000_00FF << sh_b))
                         | ({24'b0, dato_st_i[7:0]} << sh_b);
            end
            TAM_MEDIA: begin
                carga_o  = {{16{~sin_signo_i & lane_h[15]}}, lane_h};
                fusion_o = (palabra_i & ~(32'h0000_FFFF << sh_h))
                         | ({16'b0, dato_st_i[15:0]} << sh_h);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/unidad_carga_almacenamiento.sv
// Load/store unit: converts byte/half/word accesses at byte addresses into
// word accesses, using read-modify-write for sub-word stores.
module unidad_carga_almacenamiento
    import ldst_pkg::*;
#(
    parameter int NUM_PALABRAS = NUM_PALABRAS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inicio,
    input  logic        es_escritura,
    input  logic [1:0]  tamano,
    input  logic        sin_signo,
    input  logic [31:0] direccion,
    input  logic [31:0] dato_in,
    output logic        ocupado,
    output logic        listo,
    output logic        error_alineacion,
    output logic [31:0] dato_out,
    output logic [31:0] mem_direccion,
    output logic        mem_MemWrite,
    output logic [31:0] mem_datoEscritura,
    input  logic [31:0] mem_datoLectura
);

    localparam int          IW     = $clog2(NUM_PALABRAS);
    localparam logic [31:0] LIMITE = 32'(4 * NUM_PALABRAS);

    estado_t         state_q, state_d;
    logic [IW+1:0]   dir_q, dir_d;
    logic [31:0]     dato_q, dato_d;
    logic [1:0]      tam_q, tam_d;
    logic            esc_q, esc_d;
    logic            sin_q, sin_d;
    logic            err_q, err_d;
    logic [31:0]     dout_q, dout_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            memwrite_q, memwrite_d;
    logic            ilegal;
    logic [31:0]     carga, fusion;

    always_comb begin
        ilegal = 1'b0;
        case (tamano)
            TAM_BYTE:    ilegal = 1'b0;
            TAM_MEDIA:   ilegal = direccion[0];
            TAM_PALABRA: ilegal = |direccion[1:0];
            default:     ilegal = 1'b1;
        endcase
        if (direccion >= LIMITE) ilegal = 1'b1;
    end

    alineador_bytes u_alineador (
        .palabra_i   (mem_datoLectura),
        .offset_i    (dir_q[1:0]),
        .tamano_i    (tam_q),
        .sin_signo_i (sin_q),
        .dato_st_i   (dato_q),
        .carga_o     (carga),
        .fusion_o    (fusion)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (inicio) begin
                if (ilegal)                                 state_d = RESP;
                else if (es_escritura && tamano == TAM_PALABRA) state_d = ESCRIBIR;
                else                                        state_d = LEER;
            end
            LEER:     state_d = esc_q ? ESCRIBIR : RESP;
            ESCRIBIR: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ocupado = (state_q != IDLE);
        listo   = (state_q == RESP);
    end

    // Request fields are only captured on acceptance so mid-operation input
    // changes cannot disturb an access in flight.
    always_comb begin
        dir_d   = dir_q;
        dato_d  = dato_q;
        tam_d   = tam_q;
        esc_d   = esc_q;
        sin_d   = sin_q;
        err_d   = err_q;
        dout_d  = dout_q;
        wdata_d = wdata_q;
        if (state_q == IDLE && inicio) begin
            dir_d  = direccion[IW+1:0];
            dato_d = dato_in;
            tam_d  = tamano;
            esc_d  = es_escritura;
            sin_d  = sin_signo;
            err_d  = ilegal;
            if (!ilegal && es_escritura && tamano == TAM_PALABRA) wdata_d = dato_in;
        end
        if (state_q == LEER) begin
            if (esc_q) wdata_d = fusion;
            else       dout_d  = carga;
        end
        memwrite_d = (state_d == ESCRIBIR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q      <= '0;
            dato_q     <= '0;
            tam_q      <= '0;
            esc_q      <= 1'b0;
            sin_q      <= 1'b0;
            err_q      <= 1'b0;
            dout_q     <= '0;
            wdata_q    <= '0;
            memwrite_q <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            dato_q     <= dato_d;
            tam_q      <= tam_d;
            esc_q      <= esc_d;
            sin_q      <= sin_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
            wdata_q    <= wdata_d;
            memwrite_q <= memwrite_d;
        end
    end

    // Strobe comes straight from a flop so the combinational memory write
    // never sees a glitch.
    assign mem_MemWrite      = memwrite_q;
    assign mem_datoEscritura = wdata_q;
    assign mem_direccion     = {{(32-IW){1'b0}}, dir_q[IW+1:2]};
    assign error_alineacion  = err_q;
    assign dato_out          = dout_q;

endmodule

// File: tb/tb_unidad_carga_almacenamiento.sv
// Randomized self-checking bench for the load/store unit against a byte-level
// memory model kept in the bench.
module tb_unidad_carga_almacenamiento;

    logic        clk = 1'b0;
    logic        rst;
    logic        inicio;
    logic        es_escritura;
    logic [1:0]  tamano;
    logic        sin_signo;
    logic [31:0] direccion;
    logic [31:0] dato_in;
    logic        ocupado, listo, error_alineacion, mem_MemWrite;
    logic [31:0] dato_out, mem_direccion, mem_datoEscritura, mem_datoLectura;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem     [32];
    logic [31:0] ref_mem [32];
    logic [31:0] last_load;

    always #5 clk = ~clk;

    unidad_carga_almacenamiento #(.NUM_PALABRAS(32)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .es_escritura(es_escritura),
        .tamano(tamano), .sin_signo(sin_signo), .direccion(direccion),
        .dato_in(dato_in), .ocupado(ocupado), .listo(listo),
        .error_alineacion(error_alineacion), .dato_out(dato_out),
        .mem_direccion(mem_direccion), .mem_MemWrite(mem_MemWrite),
        .mem_datoEscritura(mem_datoEscritura), .mem_datoLectura(mem_datoLectura)
    );

    // Word-indexed memory with combinational read, written on the clock edge.
    assign mem_datoLectura = mem[mem_direccion[4:0]];
    always @(posedge clk) if (mem_MemWrite) mem[mem_direccion[4:0]] <= mem_datoEscritura;

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Issue one request and check latency, error, load data, write activity
    // and resulting memory word against the reference model.
    task automatic do_req(input logic wr, input logic [1:0] tam, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] data, input string name);
        logic        ill;
        int          idx, off, exp_lat, exp_wr, cyc, nwr;
        logic [31:0] w, v, waddr;
        ill = (tam == 2'b11) || (tam == 2'b01 && addr[0]) ||
              (tam == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'd128);
        idx = int'(addr[6:2]);
        off = int'(addr[1:0]);
        if (!ill) begin
            if (wr) begin
                case (tam)
                    2'b00: ref_mem[idx][off*8 +: 8]  = data[7:0];
                    2'b01: ref_mem[idx][off*8 +: 16] = data[15:0];
                    default: ref_mem[idx] = data;
                endcase
            end else begin
                w = ref_mem[idx];
                case (tam)
                    2'b00: begin v = (w >> (off*8)) & 32'hFF;   if (!sgn && v[7])  v = v | 32'hFFFF_FF00; end
                    2'b01: begin v = (w >> (off*8)) & 32'hFFFF; if (!sgn && v[15]) v = v | 32'hFFFF_0000; end
                    default: v = w;
                endcase
                last_load = v;
            end
        end
        exp_lat = ill ? 1 : (!wr ? 2 : (tam == 2'b10 ? 2 : 3));
        exp_wr  = (ill || !wr) ? 0 : 1;

        @(negedge clk);
        es_escritura = wr; tamano = tam; sin_signo = sgn; direccion = addr; dato_in = data;
        inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        cyc = 1; nwr = 0; waddr = '0;
        while (!listo && cyc < 10) begin
            if (mem_MemWrite) begin nwr++; waddr = mem_direccion; end
            @(negedge clk);
            cyc++;
        end
        if (mem_MemWrite) nwr++;

        vectors++;
        if (!listo) begin
            miscompares++; $display("FAIL %s timeout: no listo after %0d cycles", name, cyc);
            return;
        end
        vectors++;
        if (cyc !== exp_lat) begin miscompares++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat); end
        vectors++;
        if (error_alineacion !== ill) begin miscompares++; $display("FAIL %s error: got %0b want %0b", name, error_alineacion, ill); end
        vectors++;
        if (dato_out !== last_load) begin miscompares++; $display("FAIL %s dato_out: got %h want %h", name, dato_out, last_load); end
        vectors++;
        if (nwr !== exp_wr) begin miscompares++; $display("FAIL %s writes: got %0d want %0d", name, nwr, exp_wr); end
        if (exp_wr == 1) begin
            vectors++;
            if (waddr !== 32'(idx)) begin miscompares++; $display("FAIL %s write addr: got %h want %h", name, waddr, idx); end
        end
        if (!ill) begin
            vectors++;
            if (mem[idx] !== ref_mem[idx]) begin miscompares++; $display("FAIL %s mem[%0d]: got %h want %h", name, idx, mem[idx], ref_mem[idx]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inicio = 1'b0; es_escritura = 1'b0; tamano = 2'b00; sin_signo = 1'b0;
        direccion = '0; dato_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ocupado, listo, error_alineacion, dato_out, mem_direccion, mem_MemWrite, mem_datoEscritura} !== '0) begin
            miscompares++;
            $display("FAIL reset outputs: got ocu=%b listo=%b err=%b dout=%h dir=%h we=%b wd=%h want all zero",
                     ocupado, listo, error_alineacion, dato_out, mem_direccion, mem_MemWrite, mem_datoEscritura);
        end
        rst = 1'b0;
        last_load = '0;
    endtask

    task automatic test_word();
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, "word_store");
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "word_load");
    endtask

    task automatic test_byte_rmw();
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, "byte_init");
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, "byte_store");
        vectors++;
        if (mem[4] !== 32'h11AA_3344) begin miscompares++; $display("FAIL byte_merge: got %h want 11aa3344", mem[4]); end
        do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, "byte_load_s");
        vectors++;
        if (dato_out !== 32'hFFFF_FFAA) begin miscompares++; $display("FAIL byte_sext: got %h want ffffffaa", dato_out); end
        do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, "byte_load_u");
    endtask

    task automatic test_half();
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h0, "half_init");
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_8001, "half_store");
        vectors++;
        if (mem[5] !== 32'h8001_0000) begin miscompares++; $display("FAIL half_merge: got %h want 80010000", mem[5]); end
        do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, "half_load_s");
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, "half_load_u");
    endtask

    task automatic test_errors();
        do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF_FFFF, "err_half");
        do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFFF, "err_word");
        do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF, "err_tam");
        do_req(1'b1, 2'b10, 1'b0, 32'h80, 32'hFFFF_FFFF, "err_range");
        do_req(1'b0, 2'b00, 1'b0, 32'h7F, 32'h0, "edge_last_byte");
        vectors++;
        if (mem_diffs() != 0) begin miscompares++; $display("FAIL err_mem: got %0d differing words want 0", mem_diffs()); end
    endtask

    task automatic test_stall();
        int cyc = 0;
        logic bad_ocu = 1'b0;
        logic [31:0] exp = ref_mem[4];
        @(negedge clk);
        es_escritura = 1'b0; tamano = 2'b10; sin_signo = 1'b0; direccion = 32'h10; dato_in = '0;
        inicio = 1'b1;
        @(posedge clk);
        do begin
            @(negedge clk);
            cyc++;
            if (!ocupado) bad_ocu = 1'b1;
            if (!listo) begin
                es_escritura = 1'b1; tamano = 2'($urandom_range(0, 2));
                direccion = $urandom_range(0, 31) << 2; dato_in = $urandom;
            end
        end while (!listo && cyc < 10);
        inicio = 1'b0;
        last_load = exp;
        vectors++;
        if (bad_ocu) begin miscompares++; $display("FAIL stall ocupado: got low while busy want high"); end
        vectors++;
        if (cyc !== 2) begin miscompares++; $display("FAIL stall latency: got %0d want 2", cyc); end
        vectors++;
        if (dato_out !== exp) begin miscompares++; $display("FAIL stall dato_out: got %h want %h", dato_out, exp); end
        @(negedge clk);
        vectors++;
        if (ocupado !== 1'b0) begin miscompares++; $display("FAIL stall idle: got ocupado=%b want 0", ocupado); end
        vectors++;
        if (mem_diffs() != 0) begin miscompares++; $display("FAIL stall mem: got %0d differing words want 0", mem_diffs()); end
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        do_req(1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFE_F00D, "rst_init");
        @(negedge clk);
        es_escritura = 1'b1; tamano = 2'b00; sin_signo = 1'b0; direccion = 32'h19; dato_in = 32'h55;
        inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({ocupado, listo, error_alineacion, dato_out, mem_direccion, mem_MemWrite, mem_datoEscritura} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid outputs: got ocu=%b listo=%b we=%b dout=%h wd=%h want all zero",
                     ocupado, listo, mem_MemWrite, dato_out, mem_datoEscritura);
        end
        repeat (3) begin
            @(negedge clk);
            if (listo || mem_MemWrite) bad = 1'b1;
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL rst_mid activity: got listo/write after reset want none"); end
        vectors++;
        if (mem[6] !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL rst_mid mem: got %h want cafef00d", mem[6]); end
        last_load = '0;
        do_req(1'b0, 2'b00, 1'b1, 32'h19, 32'h0, "rst_after_load");
    endtask

    task automatic test_random();
        logic [1:0]  tam;
        logic [31:0] addr;
        for (int n = 0; n < 60; n++) begin
            tam  = 2'($urandom_range(0, 3));
            addr = $urandom_range(0, 135);
            if ($urandom_range(0, 3) != 0) begin
                if (tam == 2'b10) addr = addr & ~32'h3;
                if (tam == 2'b01) addr = addr & ~32'h1;
            end
            do_req(1'($urandom_range(0, 1)), tam, 1'($urandom_range(0, 1)), addr, $urandom, "random");
        end
        vectors++;
        if (mem_diffs() != 0) begin miscompares++; $display("FAIL random mem: got %0d differing words want 0", mem_diffs()); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_word();
        test_byte_rmw();
        test_half();
        test_errors();
        test_stall();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
